// File: rtl/jtag_tap.sv
// jtag_tap: IEEE 1149.1-style TAP controller with a parametrised instruction
// register and three data registers: IDCODE, BYPASS and a USER register
// that exchanges parallel data with design-side debug logic.
module jtag_tap #(
  parameter int                    IR_WIDTH     = 4,
  parameter logic [31:0]           IDCODE_VALUE = 32'h000FAF01,
  parameter int                    USER_WIDTH   = 8,
  parameter logic [IR_WIDTH-1:0]   INSTR_IDCODE = 4'b1110,
  parameter logic [IR_WIDTH-1:0]   INSTR_USER   = 4'b1000
) (
  input  logic                  tck,
  input  logic                  trst,
  input  logic                  enable,
  input  logic                  tms,
  input  logic                  tdi,
  output logic                  tdo,
  output logic                  tdo_oe,
  output logic [3:0]            tap_state,
  output logic [IR_WIDTH-1:0]   ir_value,
  input  logic [USER_WIDTH-1:0] user_dr_in,
  output logic [USER_WIDTH-1:0] user_dr_out,
  output logic                  user_update
);

  // DR shift register is shared by IDCODE (32 bits) and USER (USER_WIDTH bits).
  localparam int DR_W = (USER_WIDTH > 32) ? USER_WIDTH : 32;

  typedef enum logic [3:0] {
    S_TLR   = 4'h0, S_RTI   = 4'h1, S_SELDR = 4'h2, S_SELIR = 4'h3,
    S_CAPDR = 4'h4, S_CAPIR = 4'h5, S_SHDR  = 4'h6, S_SHIR  = 4'h7,
    S_EX1DR = 4'h8, S_EX1IR = 4'h9, S_PAUDR = 4'hA, S_PAUIR = 4'hB,
    S_EX2DR = 4'hC, S_EX2IR = 4'hD, S_UPDDR = 4'hE, S_UPDIR = 4'hF
  } tap_state_t;

  tap_state_t            r_state;
  tap_state_t            w_next;
  logic [IR_WIDTH-1:0]   r_ir_value;
  logic [IR_WIDTH-1:0]   r_ir_shift;
  logic [DR_W-1:0]       r_dr_shift;
  logic [DR_W-1:0]       w_dr_next;
  logic                  r_bypass;
  logic [USER_WIDTH-1:0] r_user_dr_out;
  logic                  r_user_update;
  logic                  w_ir_all_ones;
  logic                  w_sel_idcode;
  logic                  w_sel_user;
  logic                  w_dr_lsb;

  // An all-ones opcode always selects BYPASS, even if it collides with a parameter.
  assign w_ir_all_ones = &r_ir_value;
  assign w_sel_idcode  = (r_ir_value == INSTR_IDCODE) && !w_ir_all_ones;
  assign w_sel_user    = (r_ir_value == INSTR_USER) && !w_ir_all_ones && !w_sel_idcode;

  // TAP state register.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      r_state <= S_TLR;
    end else if (enable) begin
      r_state <= w_next;
    end
  end

  // 1149.1 next-state function on tms.
  always_comb begin
    w_next = S_TLR;
    case (r_state)
      S_TLR:   w_next = tms ? S_TLR   : S_RTI;
      S_RTI:   w_next = tms ? S_SELDR : S_RTI;
      S_SELDR: w_next = tms ? S_SELIR : S_CAPDR;
      S_SELIR: w_next = tms ? S_TLR   : S_CAPIR;
      S_CAPDR: w_next = tms ? S_EX1DR : S_SHDR;
      S_SHDR:  w_next = tms ? S_EX1DR : S_SHDR;
      S_EX1DR: w_next = tms ? S_UPDDR : S_PAUDR;
      S_PAUDR: w_next = tms ? S_EX2DR : S_PAUDR;
      S_EX2DR: w_next = tms ? S_UPDDR : S_SHDR;
      S_UPDDR: w_next = tms ? S_SELDR : S_RTI;
      S_CAPIR: w_next = tms ? S_EX1IR : S_SHIR;
      S_SHIR:  w_next = tms ? S_EX1IR : S_SHIR;
      S_EX1IR: w_next = tms ? S_UPDIR : S_PAUIR;
      S_PAUIR: w_next = tms ? S_EX2IR : S_PAUIR;
      S_EX2IR: w_next = tms ? S_UPDIR : S_SHIR;
      S_UPDIR: w_next = tms ? S_SELDR : S_RTI;
      default: w_next = S_TLR;
    endcase
  end

  // Instruction register: capture/shift/update, forced to IDCODE in TLR.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      r_ir_shift <= '0;
      r_ir_value <= INSTR_IDCODE;
    end else if (enable) begin
      case (r_state)
        S_TLR:   r_ir_value <= INSTR_IDCODE;
        S_CAPIR: r_ir_shift <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
        S_SHIR:  r_ir_shift <= {tdi, r_ir_shift[IR_WIDTH-1:1]};
        S_UPDIR: r_ir_value <= r_ir_shift;
        default: ;
      endcase
    end
  end

  // Next DR shift content: capture or shift of whichever register the IR selects.
  always_comb begin
    w_dr_next = r_dr_shift;
    if (r_state == S_CAPDR) begin
      if (w_sel_idcode) begin
        w_dr_next = DR_W'(IDCODE_VALUE);
      end else if (w_sel_user) begin
        w_dr_next = '0;
        w_dr_next[USER_WIDTH-1:0] = user_dr_in;
      end
    end else if (r_state == S_SHDR) begin
      if (w_sel_idcode) begin
        for (int i = 0; i < 31; i++) w_dr_next[i] = r_dr_shift[i+1];
        w_dr_next[31] = tdi;
      end else if (w_sel_user) begin
        for (int i = 0; i < USER_WIDTH-1; i++) w_dr_next[i] = r_dr_shift[i+1];
        w_dr_next[USER_WIDTH-1] = tdi;
      end
    end
  end

  // DR shift register and the one-bit bypass register.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      r_dr_shift <= '0;
      r_bypass   <= 1'b0;
    end else if (enable) begin
      r_dr_shift <= w_dr_next;
      if (!w_sel_idcode && !w_sel_user) begin
        if (r_state == S_CAPDR)     r_bypass <= 1'b0;
        else if (r_state == S_SHDR) r_bypass <= tdi;
      end
    end
  end

  // USER parallel output, written in UpdateDR, with a one-tck strobe.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      r_user_dr_out <= '0;
      r_user_update <= 1'b0;
    end else if (enable) begin
      r_user_update <= (r_state == S_UPDDR) && w_sel_user;
      if ((r_state == S_UPDDR) && w_sel_user) begin
        r_user_dr_out <= r_dr_shift[USER_WIDTH-1:0];
      end
    end
  end

  assign w_dr_lsb    = (w_sel_idcode || w_sel_user) ? r_dr_shift[0] : r_bypass;
  assign tdo         = (r_state == S_SHIR) ? r_ir_shift[0] :
                       (r_state == S_SHDR) ? w_dr_lsb : 1'b0;
  assign tdo_oe      = (r_state == S_SHIR) || (r_state == S_SHDR);
  assign tap_state   = r_state;
  assign ir_value    = r_ir_value;
  assign user_dr_out = r_user_dr_out;
  assign user_update = r_user_update & enable;

endmodule

// File: tb/tb_jtag_tap.sv
// tb_jtag_tap: directed, table-driven bench for jtag_tap.
module tb_jtag_tap;

  logic       tck = 1'b0;
  logic       trst, enable, tms, tdi;
  logic       tdo, tdo_oe;
  logic [3:0] tap_state;
  logic [3:0] ir_value;
  logic [7:0] user_dr_in, user_dr_out;
  logic       user_update;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] IDCODE = 32'h000FAF01;

  typedef struct {
    logic       tms;
    logic       tdi;
    logic       en;
    logic [3:0] st;
    logic       oe;
  } vec_t;

  vec_t vecs[28];

  jtag_tap dut (
    .tck(tck), .trst(trst), .enable(enable), .tms(tms), .tdi(tdi),
    .tdo(tdo), .tdo_oe(tdo_oe), .tap_state(tap_state), .ir_value(ir_value),
    .user_dr_in(user_dr_in), .user_dr_out(user_dr_out), .user_update(user_update)
  );

  always #5 tck = ~tck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One tck edge with the given inputs; returns 1 time unit after the edge.
  task automatic tick(input logic t_tms, input logic t_tdi, input logic t_en = 1'b1);
    tms = t_tms; tdi = t_tdi; enable = t_en;
    @(posedge tck);
    #1;
  endtask

  // RTI -> ShiftDR
  task automatic goto_shdr();
    tick(1, 0); tick(0, 0); tick(0, 0);
    chk("goto_shdr_state", 32'(tap_state), 32'h6);
  endtask

  // RTI -> ShiftIR, shift val LSB-first checking captured 0001, update, back to RTI.
  task automatic load_ir(input logic [3:0] val);
    logic [3:0] cap;
    cap = 4'b0001;
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ir_cap_tdo%0d", i), 32'(tdo), 32'(cap[i]));
      tick(i == 3, val[i]);
    end
    tick(1, 0); tick(0, 0);
    chk("ir_value_loaded", 32'(ir_value), 32'(val));
    chk("ir_back_rti", 32'(tap_state), 32'h1);
  endtask

  task automatic bypass_test(input logic [3:0] op);
    logic [3:0] din, dexp;
    din = 4'b1101; dexp = 4'b1010;
    load_ir(op);
    goto_shdr();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("byp_%0h_tdo%0d", op, i), 32'(tdo), 32'(dexp[i]));
      tick(i == 3, din[i]);
    end
    tick(1, 0); tick(0, 0);
  endtask

  initial begin
    logic [7:0] ushift, ucap;
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 4'h1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 4'h2, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 4'h3, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 4'h5, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'h7, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 4'h7, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 4'h9, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 4'hB, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 4'hD, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'h7, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 4'h9, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 4'hF, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 4'h2, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 4'h4, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 4'h6, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 4'h6, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 4'h6, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 4'h8, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 4'hA, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 1'b1, 4'hC, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 4'h6, 1'b1};
    vecs[21] = '{1'b1, 1'b0, 1'b1, 4'h8, 1'b0};
    vecs[22] = '{1'b1, 1'b0, 1'b1, 4'hE, 1'b0};
    vecs[23] = '{1'b0, 1'b0, 1'b1, 4'h1, 1'b0};
    vecs[24] = '{1'b1, 1'b0, 1'b1, 4'h2, 1'b0};
    vecs[25] = '{1'b1, 1'b0, 1'b1, 4'h3, 1'b0};
    vecs[26] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b0};
    vecs[27] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b0};

    trst = 1'b1; enable = 1'b1; tms = 1'b0; tdi = 1'b0; user_dr_in = 8'h3C;
    repeat (2) @(posedge tck);
    #1;
    chk("rst_state", 32'(tap_state), 32'h0);
    chk("rst_ir", 32'(ir_value), 32'hE);
    chk("rst_oe", 32'(tdo_oe), 32'h0);
    chk("rst_tdo", 32'(tdo), 32'h0);
    chk("rst_udo", 32'(user_dr_out), 32'h0);
    chk("rst_upd", 32'(user_update), 32'h0);
    trst = 1'b0;

    // FSM walk through all 16 states, with enable=0 holds.
    for (int i = 0; i < 28; i++) begin
      tick(vecs[i].tms, vecs[i].tdi, vecs[i].en);
      chk($sformatf("vec%0d_state", i), 32'(tap_state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_oe", i), 32'(tdo_oe), 32'(vecs[i].oe));
    end
    chk("tlr_ir_idcode", 32'(ir_value), 32'hE);

    // IDCODE scan, then the first shifted-in bit appears as the 33rd bit.
    tick(0, 0);
    goto_shdr();
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("idcode_bit%0d", i), 32'(tdo), 32'(IDCODE[i]));
      tick(0, i == 0);
    end
    chk("idcode_bit32", 32'(tdo), 32'h1);
    tick(1, 0); tick(1, 0); tick(0, 0);
    chk("idcode_rti", 32'(tap_state), 32'h1);

    bypass_test(4'b1111);
    bypass_test(4'b0011);

    // USER capture/shift/update.
    load_ir(4'b1000);
    user_dr_in = 8'h3C;
    goto_shdr();
    ushift = 8'hA5; ucap = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("user_tdo%0d", i), 32'(tdo), 32'(ucap[i]));
      tick(i == 7, ushift[i]);
    end
    tick(1, 0);
    chk("user_upd_state", 32'(tap_state), 32'hE);
    chk("user_upd_pre", 32'(user_update), 32'h0);
    tick(0, 0);
    chk("user_dr_out", 32'(user_dr_out), 32'hA5);
    chk("user_upd_pulse", 32'(user_update), 32'h1);
    tick(0, 0);
    chk("user_upd_clear", 32'(user_update), 32'h0);
    chk("user_dr_hold", 32'(user_dr_out), 32'hA5);

    // Mid-ShiftDR escape with five tms=1 edges.
    load_ir(4'b1111);
    goto_shdr();
    tick(0, 1); tick(0, 1);
    repeat (5) tick(1, 0);
    chk("esc_state", 32'(tap_state), 32'h0);
    chk("esc_udo", 32'(user_dr_out), 32'hA5);
    tick(1, 0);
    chk("esc_ir", 32'(ir_value), 32'hE);

    // enable=0 holds everything mid-shift.
    tick(0, 0);
    goto_shdr();
    chk("en_tdo_bit0", 32'(tdo), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 1'b0);
      chk($sformatf("en0_state%0d", i), 32'(tap_state), 32'h6);
      chk($sformatf("en0_tdo%0d", i), 32'(tdo), 32'h1);
    end
    tick(0, 0);
    chk("en1_state", 32'(tap_state), 32'h6);
    chk("en1_tdo_bit1", 32'(tdo), 32'h0);

    // Asynchronous trst during a USER shift.
    tick(1, 0); tick(1, 0); tick(0, 0);
    load_ir(4'b1000);
    goto_shdr();
    tick(0, 1); tick(0, 1); tick(0, 1);
    #2 trst = 1'b1;
    #1;
    chk("trst_state", 32'(tap_state), 32'h0);
    chk("trst_oe", 32'(tdo_oe), 32'h0);
    chk("trst_tdo", 32'(tdo), 32'h0);
    chk("trst_ir", 32'(ir_value), 32'hE);
    chk("trst_udo", 32'(user_dr_out), 32'h0);
    chk("trst_upd", 32'(user_update), 32'h0);
    @(posedge tck);
    #1 trst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
